// File: rtl/sprite_ctrl_pkg.sv
// Shared types and default geometry for the sprite motion controller.
package sprite_ctrl_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 16;

  localparam int DEF_SCREEN_W = 1280;
  localparam int DEF_SCREEN_H = 720;
  localparam int DEF_SPRITE_W = 256;
  localparam int DEF_SPRITE_H = 256;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_POP      = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

endpackage

// File: rtl/axis_stepper.sv
// One-axis clamp of a requested origin and bounded per-frame step toward the target.
module axis_stepper #(
  parameter int W    = 11,
  parameter int STEP = 8,
  parameter int MAX  = 1024
) (
  input  logic [W-1:0] i_raw,
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_tgt,
  output logic [W-1:0] o_clamped,
  output logic [W-1:0] o_next
);

  localparam int DW = W + 1;
  localparam logic [W-1:0]         LP_MAX  = W'(MAX);
  localparam logic [W-1:0]         LP_STEP = W'(STEP);
  localparam logic signed [DW-1:0] LP_STEP_S = DW'(STEP);

  function automatic logic [W-1:0] sat_max(input logic [W-1:0] v);
    return (v > LP_MAX) ? LP_MAX : v;
  endfunction

  logic signed [DW-1:0] w_diff;
  logic signed [DW-1:0] w_mag;

  // Both endpoints lie inside [0, MAX], so a full STEP never overshoots the range.
  always_comb begin
    w_diff = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
    w_mag  = w_diff[DW-1] ? -w_diff : w_diff;
    if (w_mag <= LP_STEP_S)
      o_next = i_tgt;
    else if (w_diff[DW-1])
      o_next = i_cur - LP_STEP;
    else
      o_next = i_cur + LP_STEP;
  end

  assign o_clamped = sat_max(i_raw);

endmodule

// File: rtl/sprite_motion_controller.sv
// Sprite motion sequencer: targets and pop requests are latched during the frame,
// while position, pop animation and cooldown advance only on the vertical-blank tick.
module sprite_motion_controller
  import sprite_ctrl_pkg::*;
#(
  parameter int SCREEN_W        = DEF_SCREEN_W,
  parameter int SCREEN_H        = DEF_SCREEN_H,
  parameter int SPRITE_W        = DEF_SPRITE_W,
  parameter int SPRITE_H        = DEF_SPRITE_H,
  parameter int STEP            = 8,
  parameter int POP_FRAMES      = 15,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int HOME_X          = 512,
  parameter int HOME_Y          = 232
) (
  input  logic           pixel_clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] hcount_in,
  input  logic [Y_W-1:0] vcount_in,
  input  logic           enable_in,
  input  logic           target_valid_in,
  input  logic [X_W-1:0] target_x_in,
  input  logic [Y_W-1:0] target_y_in,
  input  logic           pop_req_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           pop_out,
  output logic [1:0]     state_out,
  output logic           frame_tick_out
);

  localparam logic [Y_W-1:0]   LP_VMATCH    = Y_W'(SCREEN_H);
  localparam logic [X_W-1:0]   LP_HOME_X    = X_W'(HOME_X);
  localparam logic [Y_W-1:0]   LP_HOME_Y    = Y_W'(HOME_Y);
  localparam logic [CNT_W-1:0] LP_POP_LOAD  = CNT_W'(POP_FRAMES - 1);
  localparam logic [CNT_W-1:0] LP_COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

  state_t           r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_tgt_x;
  logic [Y_W-1:0]   r_tgt_y;
  logic             r_tgt_pend;
  logic             r_pop_pend;
  logic             r_pop;
  logic             r_tick;
  logic [CNT_W-1:0] r_cnt;

  logic             w_match;
  logic             w_off_tgt;
  logic [X_W-1:0]   w_x_clamped;
  logic [X_W-1:0]   w_x_next;
  logic [Y_W-1:0]   w_y_clamped;
  logic [Y_W-1:0]   w_y_next;

  assign w_match   = (hcount_in == '0) && (vcount_in == LP_VMATCH);
  assign w_off_tgt = (r_x != r_tgt_x) || (r_y != r_tgt_y);

  axis_stepper #(
    .W    (X_W),
    .STEP (STEP),
    .MAX  (SCREEN_W - SPRITE_W)
  ) u_axis_x (
    .i_raw     (target_x_in),
    .i_cur     (r_x),
    .i_tgt     (r_tgt_x),
    .o_clamped (w_x_clamped),
    .o_next    (w_x_next)
  );

  axis_stepper #(
    .W    (Y_W),
    .STEP (STEP),
    .MAX  (SCREEN_H - SPRITE_H)
  ) u_axis_y (
    .i_raw     (target_y_in),
    .i_cur     (r_y),
    .i_tgt     (r_tgt_y),
    .o_clamped (w_y_clamped),
    .o_next    (w_y_next)
  );

  // The tick decision uses the pending bits as they stood before this edge, so a
  // strobe coinciding with the match is carried over to the following frame.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_x        <= LP_HOME_X;
      r_y        <= LP_HOME_Y;
      r_tgt_x    <= LP_HOME_X;
      r_tgt_y    <= LP_HOME_Y;
      r_tgt_pend <= 1'b0;
      r_pop_pend <= 1'b0;
      r_pop      <= 1'b0;
      r_tick     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_tick <= w_match;

      if (pop_req_in && ((r_state == ST_IDLE) || (r_state == ST_TRACK)))
        r_pop_pend <= 1'b1;

      if (w_match) begin
        if (!enable_in) begin
          r_state    <= ST_IDLE;
          r_tgt_pend <= 1'b0;
          r_pop_pend <= 1'b0;
          r_pop      <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE, ST_TRACK: begin
              if (r_pop_pend) begin
                r_state    <= ST_POP;
                r_pop      <= 1'b1;
                r_pop_pend <= 1'b0;
                r_cnt      <= LP_POP_LOAD;
              end else if (r_state == ST_IDLE) begin
                if (r_tgt_pend) begin
                  r_tgt_pend <= 1'b0;
                  if (w_off_tgt)
                    r_state <= ST_TRACK;
                end
              end else begin
                r_x        <= w_x_next;
                r_y        <= w_y_next;
                r_tgt_pend <= 1'b0;
                if ((w_x_next == r_tgt_x) && (w_y_next == r_tgt_y) && !r_tgt_pend)
                  r_state <= ST_IDLE;
              end
            end
            ST_POP: begin
              if (r_cnt == '0) begin
                r_state <= ST_COOLDOWN;
                r_pop   <= 1'b0;
                r_cnt   <= LP_COOL_LOAD;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            ST_COOLDOWN: begin
              if (r_cnt == '0) begin
                r_tgt_pend <= 1'b0;
                r_state    <= w_off_tgt ? ST_TRACK : ST_IDLE;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          endcase
        end
      end

      if (target_valid_in) begin
        r_tgt_x    <= w_x_clamped;
        r_tgt_y    <= w_y_clamped;
        r_tgt_pend <= 1'b1;
      end
    end
  end

  assign x_out          = r_x;
  assign y_out          = r_y;
  assign pop_out        = r_pop;
  assign state_out      = r_state;
  assign frame_tick_out = r_tick;

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Scoreboard bench: a frame-level reference model queues the expected outputs for each tick.
module tb_sprite_motion_controller;

  localparam int SCREEN_H = 720;
  localparam int X_MAX    = 1024;
  localparam int Y_MAX    = 464;
  localparam int STEP     = 8;
  localparam int POP_N    = 15;
  localparam int COOL_N   = 30;
  localparam int HOME_X   = 512;
  localparam int HOME_Y   = 232;
  localparam int FL       = 10;
  localparam int S_IDLE = 0, S_TRACK = 1, S_POP = 2, S_COOL = 3;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        en;
  logic        tv;
  logic [10:0] tx;
  logic [9:0]  ty;
  logic        pr;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        pop_out;
  logic [1:0]  state_out;
  logic        tick_out;

  sprite_motion_controller dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .enable_in       (en),
    .target_valid_in (tv),
    .target_x_in     (tx),
    .target_y_in     (ty),
    .pop_req_in      (pr),
    .x_out           (x_out),
    .y_out           (y_out),
    .pop_out         (pop_out),
    .state_out       (state_out),
    .frame_tick_out  (tick_out)
  );

  typedef struct {
    int x;
    int y;
    int pop;
    int st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int hx = HOME_X, hy = HOME_Y, hpop = 0, hst = S_IDLE;

  int m_x, m_y, m_tx, m_ty, m_st, m_left, m_pop;
  bit m_tp, m_pp;
  int cnum = 0;
  bit en_g = 1'b1;
  bit rst_want = 1'b0;
  bit last_match = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int approach(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d >= -STEP && d <= STEP) return tgt;
    return (d > 0) ? cur + STEP : cur - STEP;
  endfunction

  task automatic model_reset();
    m_x = HOME_X; m_y = HOME_Y; m_tx = HOME_X; m_ty = HOME_Y;
    m_tp = 1'b0; m_pp = 1'b0; m_st = S_IDLE; m_left = 0; m_pop = 0;
  endtask

  // Frame-level behaviour: the tick acts on what was latched earlier, then this cycle's strobes latch.
  task automatic model_cycle(input bit match, input bit men, input bit mtv,
                             input int mtx, input int mty, input bit mpr);
    exp_t e;
    if (match) begin
      if (!men) begin
        m_st = S_IDLE; m_tp = 1'b0; m_pp = 1'b0; m_pop = 0;
      end else if ((m_st == S_IDLE || m_st == S_TRACK) && m_pp) begin
        m_st = S_POP; m_pp = 1'b0; m_pop = 1; m_left = POP_N;
      end else if (m_st == S_POP) begin
        m_left--;
        if (m_left == 0) begin m_st = S_COOL; m_pop = 0; m_left = COOL_N; end
      end else if (m_st == S_COOL) begin
        m_left--;
        if (m_left == 0) begin
          m_st = (m_x != m_tx || m_y != m_ty) ? S_TRACK : S_IDLE;
          m_tp = 1'b0;
        end
      end else if (m_st == S_IDLE) begin
        if (m_tp) begin
          m_tp = 1'b0;
          if (m_x != m_tx || m_y != m_ty) m_st = S_TRACK;
        end
      end else begin
        m_x = approach(m_x, m_tx);
        m_y = approach(m_y, m_ty);
        if (m_x == m_tx && m_y == m_ty && !m_tp) m_st = S_IDLE;
        m_tp = 1'b0;
      end
      e.x = m_x; e.y = m_y; e.pop = m_pop; e.st = m_st;
      q.push_back(e);
    end
    if (mpr && (m_st == S_IDLE || m_st == S_TRACK)) m_pp = 1'b1;
    if (mtv) begin
      m_tx = (mtx > X_MAX) ? X_MAX : mtx;
      m_ty = (mty > Y_MAX) ? Y_MAX : mty;
      m_tp = 1'b1;
    end
  endtask

  task automatic cyc(input bit s_tv, input int s_tx, input int s_ty, input bit s_pr);
    int pos;
    @(posedge clk);
    #1;
    rst_n = rst_want;
    pos = cnum % FL;
    cnum++;
    last_match = (pos == FL - 1);
    if (pos == FL - 1) begin
      hcount = 11'd0; vcount = 10'(SCREEN_H);
    end else if (pos == 0) begin
      hcount = 11'd1; vcount = 10'(SCREEN_H);
    end else if (pos == 1) begin
      hcount = 11'd0; vcount = 10'(SCREEN_H - 1);
    end else begin
      hcount = 11'($urandom_range(1279, 1));
      vcount = 10'($urandom_range(719, 0));
    end
    en = en_g; tv = s_tv; tx = 11'(s_tx); ty = 10'(s_ty); pr = s_pr;
    if (rst_n) model_cycle(last_match, en_g, s_tv, s_tx, s_ty, s_pr);
  endtask

  task automatic run_frames(input int n);
    int m;
    m = 0;
    while (m < n) begin
      cyc(1'b0, 0, 0, 1'b0);
      if (last_match) m++;
    end
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic pulse(input bit s_tv, input int s_tx, input int s_ty, input bit s_pr);
    if ((cnum % FL) == FL - 1) cyc(1'b0, 0, 0, 1'b0);
    cyc(s_tv, s_tx, s_ty, s_pr);
  endtask

  task automatic chk_out(input string name, input int ex, input int ey, input int ep, input int es);
    chk({name, "_x"}, x_out, ex);
    chk({name, "_y"}, y_out, ey);
    chk({name, "_pop"}, pop_out, ep);
    chk({name, "_state"}, state_out, es);
  endtask

  // Called right after cyc returns, so reset lands mid-cycle with no clock edge before the check.
  task automatic do_reset_mid();
    #2;
    rst_n = 1'b0;
    rst_want = 1'b0;
    #1;
    chk_out("reset_async", HOME_X, HOME_Y, 0, S_IDLE);
    chk("reset_tick", tick_out, 0);
    model_reset();
    q.delete();
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    rst_want = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hx = HOME_X; hy = HOME_Y; hpop = 0; hst = S_IDLE;
    end else begin
      if (tick_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: got tick with no pending frame (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          hx = e.x; hy = e.y; hpop = e.pop; hst = e.st;
        end
        chk("tick_x", x_out, hx);
        chk("tick_y", y_out, hy);
        chk("tick_pop", pop_out, hpop);
        chk("tick_state", state_out, hst);
        chk("tick_x_bound", (x_out <= X_MAX) ? 1 : 0, 1);
        chk("tick_y_bound", (y_out <= Y_MAX) ? 1 : 0, 1);
      end else begin
        chk("hold_x", x_out, hx);
        chk("hold_y", y_out, hy);
        chk("hold_pop", pop_out, hpop);
        chk("hold_state", state_out, hst);
      end
    end
  end

  initial begin
    int r_tv, r_pr, is_m;
    rst_n = 1'b0; hcount = '0; vcount = '0; en = 1'b1; tv = 1'b0; tx = '0; ty = '0; pr = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    chk_out("reset_init", HOME_X, HOME_Y, 0, S_IDLE);
    chk("reset_init_tick", tick_out, 0);
    rst_want = 1'b1;

    pulse(1'b1, 600, 232, 1'b0);
    run_frames(1);
    chk_out("track_enter", HOME_X, HOME_Y, 0, S_TRACK);
    run_frames(1);
    chk_out("track_step1", 520, 232, 0, S_TRACK);
    run_frames(11);
    chk_out("track_done", 600, 232, 0, S_IDLE);

    pulse(1'b1, 1200, 700, 1'b0);
    run_frames(60);
    chk_out("clamp_done", X_MAX, Y_MAX, 0, S_IDLE);

    pulse(1'b0, 0, 0, 1'b1);
    run_frames(1);
    chk_out("pop_first", X_MAX, Y_MAX, 1, S_POP);
    run_frames(14);
    chk_out("pop_last", X_MAX, Y_MAX, 1, S_POP);
    run_frames(1);
    chk_out("cool_enter", X_MAX, Y_MAX, 0, S_COOL);
    pulse(1'b0, 0, 0, 1'b1);
    run_frames(29);
    chk_out("cool_last", X_MAX, Y_MAX, 0, S_COOL);
    run_frames(1);
    chk_out("cool_exit", X_MAX, Y_MAX, 0, S_IDLE);

    pulse(1'b0, 0, 0, 1'b1);
    run_frames(5);
    chk_out("abort_in_pop", X_MAX, Y_MAX, 1, S_POP);
    en_g = 1'b0;
    run_frames(1);
    chk_out("abort_done", X_MAX, Y_MAX, 0, S_IDLE);
    en_g = 1'b1;
    run_frames(2);
    chk_out("abort_stays", X_MAX, Y_MAX, 0, S_IDLE);

    while ((cnum % FL) != FL - 2) cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b1, 100, 50, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    chk_out("simul_pop", X_MAX, Y_MAX, 1, S_POP);
    run_frames(45);
    chk_out("simul_track", X_MAX, Y_MAX, 0, S_TRACK);
    run_frames(130);
    chk_out("simul_done", 100, 50, 0, S_IDLE);

    pulse(1'b1, 700, 300, 1'b0);
    run_frames(4);
    do_reset_mid();
    run_frames(2);
    chk_out("reset_after", HOME_X, HOME_Y, 0, S_IDLE);

    for (int f = 0; f < 300; f++) begin
      en_g = ($urandom_range(15, 0) != 0);
      if ($urandom_range(199, 0) == 0) do_reset_mid();
      for (int c = 0; c < FL; c++) begin
        is_m = ((cnum % FL) == FL - 1) ? 1 : 0;
        r_tv = ($urandom_range(19, 0) == 0) ? 1 : 0;
        r_pr = (is_m == 0 && $urandom_range(59, 0) == 0) ? 1 : 0;
        cyc(r_tv[0], int'($urandom_range(2047, 0)), int'($urandom_range(1023, 0)), r_pr[0]);
      end
    end

    en_g = 1'b1;
    run_frames(2);
    cyc(1'b0, 0, 0, 1'b0);
    chk("frames_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion_controller.md
Name: sprite_motion_controller

Overview:
- Frame-synchronous sequencer for the 256x256 palette sprite.
- Takes target positions and "pop" requests from the hand-gesture pipeline.
- Drives the sprite's x/y origin and pop-frame select.
- Updates happen only in vertical blanking, so the sprite never tears mid-frame.

Parameters:
SCREEN_W, 1280, active pixels per line
SCREEN_H, 720, active lines per frame
SPRITE_W, 256, sprite width in pixels
SPRITE_H, 256, sprite height in pixels
STEP, 8, max per-axis movement per frame (pixels, >=1)
POP_FRAMES, 15, frames pop_out stays high per pop (>=1)
COOLDOWN_FRAMES, 30, frames after a pop during which requests are dropped (>=1)
HOME_X, 512, reset x origin
HOME_Y, 232, reset y origin

Ports:
pixel_clk_in  in  1  pixel clock; the only clock
rst_in  in  1  asynchronous, active-low reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current line
enable_in  in  1  controller enable; low parks the sprite
target_valid_in  in  1  single-cycle strobe qualifying target_x_in/target_y_in
target_x_in  in  11  requested sprite x origin
target_y_in  in  10  requested sprite y origin
pop_req_in  in  1  single-cycle pop request (gesture detected)
x_out  out  11  sprite x origin
y_out  out  10  sprite y origin
pop_out  out  1  selects pop frame in sprite ROM
state_out  out  2  current FSM state encoding
frame_tick_out  out  1  one-cycle frame-boundary pulse

Behaviour:
- Reset (rst_in=0, async):
  - x_out=HOME_X, y_out=HOME_Y, pop_out=0, state=IDLE (2'd0), frame_tick_out=0.
  - Frame counter=0; tgt_pending=0; pop_pending=0.
- Frame tick:
  - frame_tick_out is registered high for exactly 1 cycle, on the cycle after hcount_in==0 && vcount_in==SCREEN_H.
  - All state/x/y/pop changes occur only on the tick cycle, which gives 1-cycle latency from the match.
  - Outputs are stable for all active-video cycles.
- Target latch, every cycle:
  - On target_valid_in, clamp x to [0, SCREEN_W-SPRITE_W] and y to [0, SCREEN_H-SPRITE_H].
  - Store the clamped values in tgt_x/tgt_y and set tgt_pending. The last strobe before a tick wins.
  - A strobe arriving on the tick cycle itself is not used by that tick; it stays pending for the next tick.
- Pop latch:
  - pop_req_in sets pop_pending only while state is IDLE or TRACK.
  - Requests arriving in POP or COOLDOWN are dropped.
  - pop_pending clears when consumed by the tick.
- FSM (IDLE=0, TRACK=1, POP=2, COOLDOWN=3); evaluated on tick, in priority order:
  1. enable_in=0: go to IDLE; clear both pending bits; pop_out=0; position held. This aborts POP/COOLDOWN.
  2. IDLE/TRACK with pop_pending: go to POP; pop_out=1; counter=POP_FRAMES-1; position frozen.
  3. POP: if counter==0, go to COOLDOWN with pop_out=0 and counter=COOLDOWN_FRAMES-1. Otherwise decrement.
  4. COOLDOWN: if counter==0, go to TRACK if (x,y)!=(tgt_x,tgt_y), else IDLE. Otherwise decrement.
  5. IDLE with tgt_pending and target!=position: go to TRACK; clear tgt_pending.
  6. TRACK: step each axis. When both axes equal the target and tgt_pending=0, go to IDLE.
- pop_out is high for exactly POP_FRAMES ticks per accepted request.
- Axis step, signed 12-bit difference d=tgt-cur:
  - If |d|<=STEP, cur=tgt; else cur+=sign(d)*STEP.
  - Result never leaves the clamped range; no wrap-around.
  - Position does not move in POP/COOLDOWN; the target stays latched for afterwards.
- Reset asserted mid-operation returns everything to reset values immediately. After release, the first update is on the next tick.

Decomposition:
- Package sprite_ctrl_pkg:
  - State enum typedef (2-bit).
  - Default screen/sprite dimension constants.
  - Coordinate widths (11-bit x, 10-bit y).
- One sub-module, axis_stepper, parameterised by width, STEP and MAX, instantiated twice (x, y).
  - Holds the clamp and step arithmetic.
  - Purely combinational; registers stay in the parent.

Test Plan:
- Reset: assert rst_in=0 mid-line -> x_out=512, y_out=232, pop_out=0, state_out=0 with no clock edge needed; first change only after the next tick.
- Tracking:
  - Strobe target (600,232) in active video -> state TRACK at next tick.
  - x_out steps 520, 528, … 600 on 11 successive ticks, then IDLE.
- Clamp: target (1200,700) -> final x_out=1024, y_out=464; never exceeds either bound.
- Pop sequence: pop_req_in in IDLE -> pop_out high exactly 15 ticks, then COOLDOWN for 30 ticks.
- Pop during cooldown: second pop_req_in in COOLDOWN is ignored; state ends IDLE.
- Abort: enable_in=0 during POP frame 5 -> next tick state IDLE, pop_out=0, position unchanged.
- Simultaneous: target strobe on the exact tick cycle, together with pop_req one cycle earlier -> this tick enters POP.
  - Target is applied only after COOLDOWN completes (TRACK toward it).
